// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer for the fetch stage.
// Gives fetch a zero-latency hit/target/direction hint and learns from
// EX-stage branch results. The array is cleared by an internal sweep
// after reset and after a flush. Entries themselves are never reset.
// Optional build macro: BTB_STATS_EN adds saturating lookup, hit and
// mispredict counters on extra output ports.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package branch_pkg;
    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;
endpackage

module branch_target_buffer
    import branch_pkg::*;
#(
    parameter int unsigned INDEX_BITS    = 6,
    parameter int unsigned TAG_BITS      = 16,
    parameter logic [1:0]  JUMP_INIT_CTR = 2'b11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_flush,
    output logic                   o_ready,
    input  logic                   i_lookup_valid,
    input  logic [`ADDR_WIDTH-1:0] i_lookup_pc,
    output logic                   o_lookup_hit,
    output logic [`ADDR_WIDTH-1:0] o_lookup_target,
    output BranchOutcome           o_lookup_prediction,
    input  logic                   i_upd_valid,
    input  logic [`ADDR_WIDTH-1:0] i_upd_pc,
    input  logic [`ADDR_WIDTH-1:0] i_upd_target,
    input  BranchOutcome           i_upd_outcome,
    input  logic                   i_upd_is_jump
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]            o_stat_lookups,
    output logic [31:0]            o_stat_hits,
    output logic [31:0]            o_stat_mispredicts
`endif
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;
    localparam int unsigned AW      = `ADDR_WIDTH;
    localparam int unsigned TAG_LO  = INDEX_BITS + 2;
    localparam int unsigned TAG_HI  = INDEX_BITS + TAG_BITS + 1;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } BtbState;

    BtbState               state_q, state_d;
    logic [INDEX_BITS-1:0] sweepIdx_q, sweepIdx_d;

    logic                  validArr_q  [ENTRIES];
    logic [TAG_BITS-1:0]   tagArr_q    [ENTRIES];
    logic [AW-1:0]         targetArr_q [ENTRIES];
    logic [1:0]            ctrArr_q    [ENTRIES];

    logic [INDEX_BITS-1:0] lookupIdx;
    logic [TAG_BITS-1:0]   lookupTag;
    logic [INDEX_BITS-1:0] updIdx;
    logic [TAG_BITS-1:0]   updTag;
    logic                  lookupRawHit;
    logic                  updHit;
    logic                  updAccept;
    logic                  entWe;
    logic [AW-1:0]         entTarget;
    logic [1:0]            entCtr;
    logic                  unusedPcBits;

    assign lookupIdx = i_lookup_pc[INDEX_BITS+1:2];
    assign lookupTag = i_lookup_pc[TAG_HI:TAG_LO];
    assign updIdx    = i_upd_pc[INDEX_BITS+1:2];
    assign updTag    = i_upd_pc[TAG_HI:TAG_LO];

    // PC bits below the index and above the tag play no part in matching.
    assign unusedPcBits = ^{i_lookup_pc[AW-1:TAG_HI+1], i_lookup_pc[1:0],
                            i_upd_pc[AW-1:TAG_HI+1], i_upd_pc[1:0]};

    assign o_ready   = (state_q == READY);
    assign updHit    = validArr_q[updIdx] && (tagArr_q[updIdx] == updTag);
    assign updAccept = (state_q == READY) && i_upd_valid && !i_flush;

    // State and sweep pointer; reset lands in INIT so the array gets cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            sweepIdx_q <= '0;
        end else begin
            state_q    <= state_d;
            sweepIdx_q <= sweepIdx_d;
        end
    end

    // Sweep one entry per cycle; a flush from either state restarts at entry 0.
    always_comb begin
        state_d    = state_q;
        sweepIdx_d = sweepIdx_q;
        case (state_q)
            INIT: begin
                if (i_flush) begin
                    sweepIdx_d = '0;
                end else if (sweepIdx_q == {INDEX_BITS{1'b1}}) begin
                    state_d    = READY;
                    sweepIdx_d = '0;
                end else begin
                    sweepIdx_d = sweepIdx_q + 1'b1;
                end
            end
            READY: begin
                if (i_flush) begin
                    state_d    = INIT;
                    sweepIdx_d = '0;
                end
            end
            default: begin
                state_d    = INIT;
                sweepIdx_d = '0;
            end
        endcase
    end

    // Zero-latency lookup from the registered array, forced to a miss when idle or sweeping.
    always_comb begin
        lookupRawHit        = validArr_q[lookupIdx] && (tagArr_q[lookupIdx] == lookupTag);
        o_lookup_hit        = 1'b0;
        o_lookup_target     = '0;
        o_lookup_prediction = NOT_TAKEN;
        if ((state_q == READY) && i_lookup_valid && lookupRawHit) begin
            o_lookup_hit        = 1'b1;
            o_lookup_target     = targetArr_q[lookupIdx];
            o_lookup_prediction = ctrArr_q[lookupIdx][1] ? TAKEN : NOT_TAKEN;
        end
    end

    // Work out what the resolved branch does to its entry: train, retarget or allocate.
    always_comb begin
        entWe     = 1'b0;
        entTarget = targetArr_q[updIdx];
        entCtr    = ctrArr_q[updIdx];
        if (updAccept) begin
            if (updHit) begin
                entWe = 1'b1;
                if (i_upd_is_jump) begin
                    entCtr    = JUMP_INIT_CTR;
                    entTarget = i_upd_target;
                end else if (i_upd_outcome == TAKEN) begin
                    entCtr    = (ctrArr_q[updIdx] == 2'b11) ? 2'b11 : ctrArr_q[updIdx] + 2'b01;
                    entTarget = i_upd_target;
                end else begin
                    entCtr    = (ctrArr_q[updIdx] == 2'b00) ? 2'b00 : ctrArr_q[updIdx] - 2'b01;
                end
            end else if (i_upd_is_jump || (i_upd_outcome == TAKEN)) begin
                entWe     = 1'b1;
                entTarget = i_upd_target;
                entCtr    = i_upd_is_jump ? JUMP_INIT_CTR : 2'b10;
            end
        end
    end

    // Array storage: the sweep clears valid bits, otherwise accepted updates write the entry.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            validArr_q[sweepIdx_q] <= 1'b0;
        end else if (entWe) begin
            validArr_q[updIdx]  <= 1'b1;
            tagArr_q[updIdx]    <= updTag;
            targetArr_q[updIdx] <= entTarget;
            ctrArr_q[updIdx]    <= entCtr;
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0]  statLookups_q;
    logic [31:0]  statHits_q;
    logic [31:0]  statMispredicts_q;
    BranchOutcome updPrediction;

    assign updPrediction      = (updHit && ctrArr_q[updIdx][1]) ? TAKEN : NOT_TAKEN;
    assign o_stat_lookups     = statLookups_q;
    assign o_stat_hits        = statHits_q;
    assign o_stat_mispredicts = statMispredicts_q;

    // Saturating event counters, cleared together with the array on a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            statLookups_q     <= '0;
            statHits_q        <= '0;
            statMispredicts_q <= '0;
        end else if (i_flush) begin
            statLookups_q     <= '0;
            statHits_q        <= '0;
            statMispredicts_q <= '0;
        end else begin
            if ((state_q == READY) && i_lookup_valid && (statLookups_q != '1)) begin
                statLookups_q <= statLookups_q + 32'd1;
            end
            if (o_lookup_hit && (statHits_q != '1)) begin
                statHits_q <= statHits_q + 32'd1;
            end
            if (updAccept && (updPrediction != i_upd_outcome) && (statMispredicts_q != '1)) begin
                statMispredicts_q <= statMispredicts_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer (default build, no stats).
// Directed scenarios plus a randomized run against a behavioural BTB model.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_branch_target_buffer;
    import branch_pkg::*;

    localparam int AW      = `ADDR_WIDTH;
    localparam int NUM_ENT = 64;
    localparam int TAG_MOD = 65536;
    localparam int SWEEP   = 64;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          ready;
    logic          lookupValid;
    logic [AW-1:0] lookupPc;
    logic          lookupHit;
    logic [AW-1:0] lookupTarget;
    BranchOutcome  lookupPred;
    logic          updValid;
    logic [AW-1:0] updPc;
    logic [AW-1:0] updTarget;
    BranchOutcome  updOutcome;
    logic          updIsJump;

    int total = 0;
    int bad   = 0;

    // Behavioural model: plain arrays plus a countdown of sweep cycles left.
    bit            mValid  [NUM_ENT];
    int            mTag    [NUM_ENT];
    logic [AW-1:0] mTarget [NUM_ENT];
    int            mCtr    [NUM_ENT];
    int            mInitLeft;

    branch_target_buffer dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_flush             (flush),
        .o_ready             (ready),
        .i_lookup_valid      (lookupValid),
        .i_lookup_pc         (lookupPc),
        .o_lookup_hit        (lookupHit),
        .o_lookup_target     (lookupTarget),
        .o_lookup_prediction (lookupPred),
        .i_upd_valid         (updValid),
        .i_upd_pc            (updPc),
        .i_upd_target        (updTarget),
        .i_upd_outcome       (updOutcome),
        .i_upd_is_jump       (updIsJump)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void modelInvalidate();
        for (int i = 0; i < NUM_ENT; i++) mValid[i] = 1'b0;
        mInitLeft = SWEEP;
    endfunction

    function automatic void modelLookup(input logic lv, input logic [AW-1:0] pc,
                                        output logic hit, output logic [AW-1:0] tgt,
                                        output BranchOutcome pred);
        int idx = int'((pc >> 2) % NUM_ENT);
        int tag = int'((pc >> 8) % TAG_MOD);
        hit  = (mInitLeft == 0) && lv && mValid[idx] && (mTag[idx] == tag);
        tgt  = hit ? mTarget[idx] : '0;
        pred = (hit && mCtr[idx] >= 2) ? TAKEN : NOT_TAKEN;
    endfunction

    function automatic void modelUpdate(input logic [AW-1:0] pc, input logic [AW-1:0] tgt,
                                        input BranchOutcome out, input logic jmp);
        int idx = int'((pc >> 2) % NUM_ENT);
        int tag = int'((pc >> 8) % TAG_MOD);
        bit hit = mValid[idx] && (mTag[idx] == tag);
        if (hit) begin
            if (jmp) begin
                mCtr[idx] = 3;
                mTarget[idx] = tgt;
            end else if (out == TAKEN) begin
                mCtr[idx] = (mCtr[idx] + 1 > 3) ? 3 : mCtr[idx] + 1;
                mTarget[idx] = tgt;
            end else begin
                mCtr[idx] = (mCtr[idx] - 1 < 0) ? 0 : mCtr[idx] - 1;
            end
        end else if (jmp || out == TAKEN) begin
            mValid[idx]  = 1'b1;
            mTag[idx]    = tag;
            mTarget[idx] = tgt;
            mCtr[idx]    = jmp ? 3 : 2;
        end
    endfunction

    function automatic void modelStep();
        if (!rst_n || flush) modelInvalidate();
        else if (mInitLeft > 0) mInitLeft--;
        else if (updValid) modelUpdate(updPc, updTarget, updOutcome, updIsJump);
    endfunction

    task automatic applyStimulus(input logic fl, input logic lv, input logic [AW-1:0] lpc,
                                 input logic uv, input logic [AW-1:0] upc,
                                 input logic [AW-1:0] utgt, input BranchOutcome uout,
                                 input logic ujmp);
        flush       = fl;
        lookupValid = lv;
        lookupPc    = lpc;
        updValid    = uv;
        updPc       = upc;
        updTarget   = utgt;
        updOutcome  = uout;
        updIsJump   = ujmp;
    endtask

    task automatic stepClock();
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        modelInvalidate();
        applyStimulus(1'b0, 1'b1, AW'(32'h100), 1'b0, '0, '0, NOT_TAKEN, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (ready !== 1'b0 || lookupHit !== 1'b0 || lookupTarget !== '0 || lookupPred !== NOT_TAKEN) begin
            bad++;
            $display("[TB] FAIL reset_state: got ready=%0b hit=%0b tgt=%h pred=%0d want 0 0 0 0",
                     ready, lookupHit, lookupTarget, lookupPred);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < SWEEP; i++) begin
            applyStimulus(1'b0, 1'b1, AW'(32'h100), (i == 10), AW'(32'h100), AW'(32'h1234), TAKEN, 1'b0);
            #1;
            total++;
            if (ready !== 1'b0 || lookupHit !== 1'b0 || lookupPred !== NOT_TAKEN) begin
                bad++;
                $display("[TB] FAIL init_cycle_%0d: got ready=%0b hit=%0b pred=%0d want 0 0 0",
                         i + 1, ready, lookupHit, lookupPred);
            end
            stepClock();
        end
        applyStimulus(1'b0, 1'b1, AW'(32'h100), 1'b0, '0, '0, NOT_TAKEN, 1'b0);
        #1;
        total++;
        if (ready !== 1'b1 || lookupHit !== 1'b0) begin
            bad++;
            $display("[TB] FAIL ready_after_sweep: got ready=%0b hit=%0b want ready=1 hit=0", ready, lookupHit);
        end
    endtask

    task automatic test_counter();
        BranchOutcome  seqOut  [9];
        BranchOutcome  seqPred [9];
        logic [AW-1:0] expTgt;
        logic [AW-1:0] stepTgt;
        seqOut  = '{TAKEN, NOT_TAKEN, NOT_TAKEN, NOT_TAKEN, TAKEN, TAKEN, TAKEN, TAKEN, NOT_TAKEN};
        seqPred = '{TAKEN, NOT_TAKEN, NOT_TAKEN, NOT_TAKEN, NOT_TAKEN, TAKEN, TAKEN, TAKEN, TAKEN};
        expTgt  = '0;
        for (int k = 0; k < 9; k++) begin
            stepTgt = AW'(32'h480 + 32'(k) * 32'h10);
            if (seqOut[k] == TAKEN) expTgt = stepTgt;
            applyStimulus(1'b0, 1'b0, '0, 1'b1, AW'(32'h400), stepTgt, seqOut[k], 1'b0);
            stepClock();
            applyStimulus(1'b0, 1'b1, AW'(32'h400), 1'b0, '0, '0, NOT_TAKEN, 1'b0);
            #1;
            total++;
            if (lookupHit !== 1'b1 || lookupTarget !== expTgt || lookupPred !== seqPred[k]) begin
                bad++;
                $display("[TB] FAIL counter_step_%0d: got hit=%0b tgt=%h pred=%0d want hit=1 tgt=%h pred=%0d",
                         k, lookupHit, lookupTarget, lookupPred, expTgt, seqPred[k]);
            end
        end
    endtask

    task automatic test_jump();
        BranchOutcome jOut  [5];
        logic         jJmp  [5];
        logic [31:0]  jTgt  [5];
        logic         eHit  [5];
        logic [31:0]  eTgt  [5];
        BranchOutcome ePred [5];
        jOut  = '{NOT_TAKEN, TAKEN, NOT_TAKEN, NOT_TAKEN, TAKEN};
        jJmp  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        jTgt  = '{32'h7000, 32'h9000, 32'h7700, 32'h7800, 32'hA000};
        eHit  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        eTgt  = '{32'h0, 32'h9000, 32'h9000, 32'h9000, 32'hA000};
        ePred = '{NOT_TAKEN, TAKEN, TAKEN, NOT_TAKEN, TAKEN};
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b1, AW'(32'h500), AW'(jTgt[k]), jOut[k], jJmp[k]);
            stepClock();
            applyStimulus(1'b0, 1'b1, AW'(32'h500), 1'b0, '0, '0, NOT_TAKEN, 1'b0);
            #1;
            total++;
            if (lookupHit !== eHit[k] || lookupTarget !== AW'(eTgt[k]) || lookupPred !== ePred[k]) begin
                bad++;
                $display("[TB] FAIL jump_step_%0d: got hit=%0b tgt=%h pred=%0d want hit=%0b tgt=%h pred=%0d",
                         k, lookupHit, lookupTarget, lookupPred, eHit[k], eTgt[k], ePred[k]);
            end
        end
        applyStimulus(1'b0, 1'b1, AW'(32'h400), 1'b0, '0, '0, NOT_TAKEN, 1'b0);
        #1;
        total++;
        if (lookupHit !== 1'b0) begin
            bad++;
            $display("[TB] FAIL jump_replaced_old: got hit=%0b want hit=0", lookupHit);
        end
    endtask

    task automatic test_alias();
        applyStimulus(1'b0, 1'b0, '0, 1'b1, AW'(32'h400), AW'(32'h480), TAKEN, 1'b0);
        stepClock();
        applyStimulus(1'b0, 1'b1, AW'(32'h10400), 1'b1, AW'(32'h10400), AW'(32'h1480), TAKEN, 1'b0);
        #1;
        total++;
        if (lookupHit !== 1'b0) begin
            bad++;
            $display("[TB] FAIL alias_no_bypass: got hit=%0b want hit=0", lookupHit);
        end
        stepClock();
        applyStimulus(1'b0, 1'b1, AW'(32'h400), 1'b0, '0, '0, NOT_TAKEN, 1'b0);
        #1;
        total++;
        if (lookupHit !== 1'b0) begin
            bad++;
            $display("[TB] FAIL alias_old_evicted: got hit=%0b want hit=0", lookupHit);
        end
        applyStimulus(1'b0, 1'b1, AW'(32'hFF010400), 1'b1, AW'(32'h10400), AW'(32'h2000), NOT_TAKEN, 1'b0);
        #1;
        total++;
        if (lookupHit !== 1'b1 || lookupTarget !== AW'(32'h1480) || lookupPred !== TAKEN) begin
            bad++;
            $display("[TB] FAIL alias_new_hit: got hit=%0b tgt=%h pred=%0d want hit=1 tgt=1480 pred=1",
                     lookupHit, lookupTarget, lookupPred);
        end
        stepClock();
        applyStimulus(1'b0, 1'b1, AW'(32'h10400), 1'b0, '0, '0, NOT_TAKEN, 1'b0);
        #1;
        total++;
        if (lookupHit !== 1'b1 || lookupTarget !== AW'(32'h1480) || lookupPred !== NOT_TAKEN) begin
            bad++;
            $display("[TB] FAIL alias_after_nt: got hit=%0b tgt=%h pred=%0d want hit=1 tgt=1480 pred=0",
                     lookupHit, lookupTarget, lookupPred);
        end
    endtask

    function automatic logic [AW-1:0] randPc();
        logic [31:0] upper = 32'($urandom_range(0, 255)) << 24;
        logic [31:0] tag   = 32'($urandom_range(0, 2)) << 8;
        logic [31:0] idx   = 32'($urandom_range(0, 7)) << 2;
        return AW'(upper | tag | idx | 32'($urandom_range(0, 3)));
    endfunction

    task automatic test_random();
        logic          eHit;
        logic [AW-1:0] eTgt;
        BranchOutcome  ePred;
        logic [AW-1:0] uPc;
        logic [AW-1:0] lPc;
        for (int n = 0; n < 600; n++) begin
            uPc = randPc();
            lPc = ($urandom_range(0, 2) == 0) ? uPc : randPc();
            applyStimulus($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0, lPc,
                          $urandom_range(0, 1) == 1, uPc, AW'($urandom),
                          ($urandom_range(0, 1) == 1) ? TAKEN : NOT_TAKEN,
                          $urandom_range(0, 4) == 0);
            #1;
            modelLookup(lookupValid, lPc, eHit, eTgt, ePred);
            total++;
            if (ready !== (mInitLeft == 0) || lookupHit !== eHit || lookupTarget !== eTgt || lookupPred !== ePred) begin
                bad++;
                $display("[TB] FAIL random_%0d pc=%h: got ready=%0b hit=%0b tgt=%h pred=%0d want ready=%0b hit=%0b tgt=%h pred=%0d",
                         n, lPc, ready, lookupHit, lookupTarget, lookupPred,
                         (mInitLeft == 0), eHit, eTgt, ePred);
            end
            stepClock();
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0, NOT_TAKEN, 1'b0);
        for (int n = 0; n < SWEEP + 1 && mInitLeft > 0; n++) stepClock();
    endtask

    task automatic test_flush_update();
        logic [31:0] oldPcs [4];
        oldPcs = '{32'h10400, 32'h500, 32'h600, 32'h0};
        applyStimulus(1'b0, 1'b0, '0, 1'b1, AW'(32'h0), AW'(32'h40), TAKEN, 1'b1);
        stepClock();
        applyStimulus(1'b1, 1'b0, '0, 1'b1, AW'(32'h600), AW'(32'h680), TAKEN, 1'b0);
        stepClock();
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0, NOT_TAKEN, 1'b0);
        for (int i = 0; i < SWEEP; i++) begin
            #1;
            total++;
            if (ready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL flush_sweep_%0d: got ready=%0b want 0", i + 1, ready);
            end
            stepClock();
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b1, AW'(oldPcs[k]), 1'b0, '0, '0, NOT_TAKEN, 1'b0);
            #1;
            total++;
            if (ready !== 1'b1 || lookupHit !== 1'b0) begin
                bad++;
                $display("[TB] FAIL flush_cleared pc=%h: got ready=%0b hit=%0b want ready=1 hit=0",
                         oldPcs[k], ready, lookupHit);
            end
        end
    endtask

    task automatic test_reset_midsweep();
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, '0, NOT_TAKEN, 1'b0);
        stepClock();
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0, NOT_TAKEN, 1'b0);
        repeat (20) stepClock();
        rst_n = 1'b0;
        modelInvalidate();
        stepClock();
        rst_n = 1'b1;
        for (int i = 0; i < SWEEP; i++) begin
            #1;
            total++;
            if (ready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL midreset_sweep_%0d: got ready=%0b want 0", i + 1, ready);
            end
            stepClock();
        end
        #1;
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midreset_ready: got ready=%0b want 1", ready);
        end
    endtask

    initial begin
        $display("[TB] starting branch_target_buffer bench");
        test_reset();
        test_counter();
        test_jump();
        test_alias();
        test_random();
        test_flush_update();
        test_reset_midsweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
